// File: rtl/l2_fill_responder_if.sv
// L1 <-> L2 line-fill interface.
//   req_*  : fill request (valid/ready), line address
//   inv_*  : single-cycle invalidate strobe with line address
//   resp_* : fill response (valid/ready), returned line address and hit flag
// master = L1 cache side, slave = L2 responder side.
interface l2_fill_responder_if #(
  parameter int unsigned ADDR_W = 26
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              inv_valid;
  logic [ADDR_W-1:0] inv_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_hit;

  modport master (
    output req_valid, req_addr, inv_valid, inv_addr, resp_ready,
    input  req_ready, resp_valid, resp_addr, resp_hit
  );

  modport slave (
    input  req_valid, req_addr, inv_valid, inv_addr, resp_ready,
    output req_ready, resp_valid, resp_addr, resp_hit
  );
endinterface

// File: rtl/l2_fill_responder.sv
// L2-side responder for L1 line fills. Requests queue in an in-order FIFO and are serviced one
// at a time: lookup in a direct-mapped tag directory, wait a hit/miss dependent latency, then
// present the response until the L1 takes it. Misses allocate the line (no writeback).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       request / invalidate / response handshake signals
//   req_cnt           lookups performed
//   hit_cnt, miss_cnt lookup outcomes
module l2_fill_responder #(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned IDX_BITS   = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HIT_LAT    = 2,
  parameter int unsigned MISS_LAT   = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  l2_fill_responder_if.slave   bus,
  output logic [CNT_W-1:0]     req_cnt,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  localparam int unsigned TAG_W    = ADDR_W - IDX_BITS;
  localparam int unsigned NUM_SETS = 1 << IDX_BITS;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_LAT  = (MISS_LAT > HIT_LAT) ? MISS_LAT : HIT_LAT;
  localparam int unsigned WCNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {StIdle, StLookup, StWait, StResp} state_e;

  // Request FIFO
  logic [ADDR_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              full, empty, push, pop;

  // Directory
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];

  // Service FSM and registered outputs
  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d, hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [IDX_BITS-1:0] cur_idx, inv_idx;
  logic [TAG_W-1:0]    cur_tag, inv_tag;
  logic                lookup_hit, fill_en, inv_match;

  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.req_valid && !full;
  assign pop   = (state_q == StIdle) && !empty;

  assign cur_idx    = cur_addr_q[IDX_BITS-1:0];
  assign cur_tag    = cur_addr_q[ADDR_W-1:IDX_BITS];
  assign inv_idx    = bus.inv_addr[IDX_BITS-1:0];
  assign inv_tag    = bus.inv_addr[ADDR_W-1:IDX_BITS];
  assign lookup_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign fill_en    = (state_q == StLookup) && !lookup_hit;
  assign inv_match  = bus.inv_valid && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Fill is applied after the invalidate so a same-cycle allocation to that index survives.
  always_comb begin
    valid_d = valid_q;
    if (inv_match) valid_d[inv_idx] = 1'b0;
    if (fill_en)   valid_d[cur_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    cur_addr_d   = cur_addr_q;
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    req_cnt_d    = req_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          cur_addr_d = fifo_mem_q[rd_ptr_q];
          state_d    = StLookup;
        end
      end
      StLookup: begin
        req_cnt_d  = req_cnt_q + CNT_W'(1);
        resp_hit_d = lookup_hit;
        if (lookup_hit) begin
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
          wcnt_d    = WCNT_W'(HIT_LAT - 1);
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          wcnt_d     = WCNT_W'(MISS_LAT - 1);
        end
        state_d = StWait;
      end
      StWait: begin
        if (wcnt_q == '0) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wcnt_q       <= '0;
      cur_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      req_cnt_q    <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      cur_addr_q   <= cur_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      req_cnt_q    <= req_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
    end
  end

  // Storage arrays need no reset: FIFO slots are gated by count, tags by valid bits.
  always_ff @(posedge clk) begin
    if (push)    fifo_mem_q[wr_ptr_q] <= bus.req_addr;
    if (fill_en) tag_q[cur_idx]       <= cur_tag;
  end

  assign bus.req_ready  = !full;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_addr  = cur_addr_q;
  assign bus.resp_hit   = resp_hit_q;
  assign req_cnt        = req_cnt_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule
